// File: rtl/cacheline_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : cacheline_adapter
//  Description : Converts whole-line read/write requests from the cache side
//                into multi-beat bursts on a narrower memory interface, and
//                reassembles returned read beats into a registered line.
//  Revision    : 1.0  initial release
// ============================================================================
module cacheline_adapter #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    // cache / arbiter side
    input  logic               read_i,
    input  logic               write_i,
    input  logic [31:0]        address_i,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    output logic               resp_o,
    // memory side
    output logic               read_o,
    output logic               write_o,
    output logic [31:0]        address_o,
    output logic [BURST_W-1:0] burst_o,
    input  logic [BURST_W-1:0] burst_i,
    input  logic               resp_i
);

    localparam int c_beats      = LINE_W / BURST_W;
    localparam int c_cnt_w      = $clog2(c_beats);
    localparam int c_line_bytes = LINE_W / 8;
    // Clears the byte-within-line offset so memory always sees aligned lines
    localparam logic [31:0] c_align_mask = ~(32'(c_line_bytes) - 32'd1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [31:0]          r_addr;
    logic [LINE_W-1:0]    r_wline;
    logic [LINE_W-1:0]    r_asm;
    logic [LINE_W-1:0]    r_line_o;
    logic [LINE_W-1:0]    w_asm_next;
    logic                 w_last;

    assign w_last = (r_cnt == c_cnt_w'(c_beats - 1));
    assign line_o = r_line_o;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and memory/requester handshake outputs
    always_comb begin
        w_next_state = r_state;
        read_o       = 1'b0;
        write_o      = 1'b0;
        resp_o       = 1'b0;
        address_o    = 32'd0;
        burst_o      = '0;
        case (r_state)
            IDLE: begin
                // read wins a tie; the losing write is simply dropped
                if (read_i) begin
                    w_next_state = RD_BURST;
                end else if (write_i) begin
                    w_next_state = WR_BURST;
                end
            end
            RD_BURST: begin
                read_o    = 1'b1;
                address_o = r_addr & c_align_mask;
                if (resp_i && w_last) begin
                    w_next_state = DONE;
                end
            end
            WR_BURST: begin
                write_o   = 1'b1;
                address_o = r_addr & c_align_mask;
                for (int b = 0; b < c_beats; b++) begin
                    if (r_cnt == c_cnt_w'(b)) begin
                        burst_o = r_wline[b*BURST_W +: BURST_W];
                    end
                end
                if (resp_i && w_last) begin
                    w_next_state = DONE;
                end
            end
            default: begin
                // DONE: single completion pulse, requests not sampled here
                resp_o       = 1'b1;
                w_next_state = IDLE;
            end
        endcase
    end

    // Assembly buffer with the incoming beat dropped into the current slot
    always_comb begin
        w_asm_next = r_asm;
        for (int b = 0; b < c_beats; b++) begin
            if (r_cnt == c_cnt_w'(b)) begin
                w_asm_next[b*BURST_W +: BURST_W] = burst_i;
            end
        end
    end

    // Request latching, beat counting and line assembly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_addr   <= 32'd0;
            r_wline  <= '0;
            r_asm    <= '0;
            r_line_o <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (read_i || write_i) begin
                        r_addr <= address_i;
                        r_cnt  <= '0;
                        if (!read_i) begin
                            r_wline <= line_i;
                        end
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        r_asm <= w_asm_next;
                        r_cnt <= r_cnt + 1'b1;
                        // line_o only moves once the whole line is in
                        if (w_last) begin
                            r_line_o <= w_asm_next;
                        end
                    end
                end
                WR_BURST: begin
                    if (resp_i) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cacheline_adapter
//  Description : Directed self-checking bench for cacheline_adapter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cacheline_adapter;

    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;

    logic               clk;
    logic               rst;
    logic               read_i;
    logic               write_i;
    logic [31:0]        address_i;
    logic [LINE_W-1:0]  line_i;
    logic [LINE_W-1:0]  line_o;
    logic               resp_o;
    logic               read_o;
    logic               write_o;
    logic [31:0]        address_o;
    logic [BURST_W-1:0] burst_o;
    logic [BURST_W-1:0] burst_i;
    logic               resp_i;

    int n_checks = 0;
    int n_fail   = 0;

    cacheline_adapter #(.LINE_W(LINE_W), .BURST_W(BURST_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .read_i    (read_i),
        .write_i   (write_i),
        .address_i (address_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .address_o (address_o),
        .burst_o   (burst_o),
        .burst_i   (burst_i),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    logic [63:0]  beats [4];
    logic [255:0] exp_line;
    logic [6:0]   stall_pat;
    int           k;

    initial begin
        rst = 1'b1; read_i = 1'b0; write_i = 1'b0; address_i = 32'd0;
        line_i = '0; burst_i = '0; resp_i = 1'b0;
        tick(); tick();
        // reset state
        chk1("rst_read_o", read_o, 1'b0);
        chk1("rst_write_o", write_o, 1'b0);
        chk1("rst_resp_o", resp_o, 1'b0);
        chk("rst_address_o", 256'(address_o), 256'd0);
        chk("rst_burst_o", 256'(burst_o), 256'd0);
        chk("rst_line_o", line_o, 256'd0);
        rst = 1'b0;
        tick();

        // ---- basic read, back-to-back beats ----
        read_i = 1'b1; address_i = 32'h1234_5678;
        tick();                                         // cycle 1
        chk1("rd_c1_read_o", read_o, 1'b1);
        chk1("rd_c1_write_o", write_o, 1'b0);
        chk("rd_c1_addr", 256'(address_o), 256'(32'h1234_5660));
        read_i = 1'b0; address_i = 32'hFFFF_FFFF; resp_i = 1'b1;
        burst_i = 64'h1111_1111_1111_1111;
        tick();                                         // cycle 2
        chk("rd_addr_held", 256'(address_o), 256'(32'h1234_5660));
        chk("rd_partial_line_o", line_o, 256'd0);
        burst_i = 64'h2222_2222_2222_2222;
        tick();                                         // cycle 3
        burst_i = 64'h3333_3333_3333_3333;
        tick();                                         // cycle 4
        chk1("rd_c4_read_o", read_o, 1'b1);
        chk1("rd_c4_resp_o", resp_o, 1'b0);
        chk("rd_c4_line_o", line_o, 256'd0);
        burst_i = 64'h4444_4444_4444_4444;
        tick();                                         // cycle 5
        resp_i = 1'b0; burst_i = '0;
        chk1("rd_c5_resp_o", resp_o, 1'b1);
        chk1("rd_c5_read_o", read_o, 1'b0);
        chk("rd_c5_addr", 256'(address_o), 256'd0);
        exp_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        chk("rd_line_o", line_o, exp_line);
        tick();                                         // cycle 6
        chk1("rd_c6_resp_o", resp_o, 1'b0);
        chk1("rd_c6_read_o", read_o, 1'b0);

        // ---- basic write ----
        write_i = 1'b1; address_i = 32'h0000_0040;
        line_i = {64'hD3D3_D3D3_D3D3_D3D3, 64'hC2C2_C2C2_C2C2_C2C2,
                  64'hB1B1_B1B1_B1B1_B1B1, 64'hA0A0_A0A0_A0A0_A0A0};
        tick();                                         // cycle 1
        chk1("wr_c1_write_o", write_o, 1'b1);
        chk1("wr_c1_read_o", read_o, 1'b0);
        chk("wr_c1_addr", 256'(address_o), 256'(32'h0000_0040));
        chk("wr_beat0", 256'(burst_o), 256'(64'hA0A0_A0A0_A0A0_A0A0));
        write_i = 1'b0; line_i = '0; resp_i = 1'b1;
        tick();                                         // cycle 2
        chk("wr_beat1", 256'(burst_o), 256'(64'hB1B1_B1B1_B1B1_B1B1));
        tick();                                         // cycle 3
        chk("wr_beat2", 256'(burst_o), 256'(64'hC2C2_C2C2_C2C2_C2C2));
        tick();                                         // cycle 4
        chk("wr_beat3", 256'(burst_o), 256'(64'hD3D3_D3D3_D3D3_D3D3));
        chk1("wr_c4_write_o", write_o, 1'b1);
        tick();                                         // cycle 5
        resp_i = 1'b0;
        chk1("wr_c5_resp_o", resp_o, 1'b1);
        chk1("wr_c5_write_o", write_o, 1'b0);
        chk("wr_c5_burst_o", 256'(burst_o), 256'd0);
        chk("wr_line_o_kept", line_o, exp_line);
        tick();                                         // cycle 6
        chk1("wr_c6_resp_o", resp_o, 1'b0);

        // ---- stalled read: resp_i pattern 1,0,0,1,1,0,1 ----
        beats[0] = 64'hE0E0_0000_0000_00E0; beats[1] = 64'hE1E1_1111_0000_00E1;
        beats[2] = 64'hE2E2_2222_0000_00E2; beats[3] = 64'hE3E3_3333_0000_00E3;
        stall_pat = 7'b1011001;                         // bit 0 is the first cycle
        read_i = 1'b1; address_i = 32'h0000_009F;
        tick();                                         // cycle 1
        read_i = 1'b0;
        chk("st_addr", 256'(address_o), 256'(32'h0000_0080));
        k = 0;
        for (int c = 0; c < 7; c++) begin
            chk1("st_read_o", read_o, 1'b1);
            chk1("st_resp_o", resp_o, 1'b0);
            resp_i  = stall_pat[c];
            burst_i = stall_pat[c] ? beats[k] : 64'hDEAD_BEEF_DEAD_BEEF;
            if (stall_pat[c]) k++;
            tick();
        end
        resp_i = 1'b0; burst_i = '0;
        chk1("st_resp_o_done", resp_o, 1'b1);
        exp_line = {beats[3], beats[2], beats[1], beats[0]};
        chk("st_line_o", line_o, exp_line);
        tick();

        // ---- simultaneous read and write: read wins ----
        read_i = 1'b1; write_i = 1'b1; address_i = 32'h0000_00C0;
        line_i = {4{64'h5A5A_5A5A_5A5A_5A5A}};
        tick();                                         // cycle 1
        read_i = 1'b0; write_i = 1'b0;
        chk1("sim_read_o", read_o, 1'b1);
        chk1("sim_write_o", write_o, 1'b0);
        chk("sim_burst_o", 256'(burst_o), 256'd0);
        resp_i = 1'b1;
        for (int b = 0; b < 4; b++) begin
            burst_i = {8{8'hF0 + 8'(b)}};
            tick();
            if (b < 3) chk1("sim_write_o_burst", write_o, 1'b0);
        end
        resp_i = 1'b0; burst_i = '0;
        chk1("sim_resp_o", resp_o, 1'b1);
        exp_line = {{8{8'hF3}}, {8{8'hF2}}, {8{8'hF1}}, {8{8'hF0}}};
        chk("sim_line_o", line_o, exp_line);
        tick();

        // ---- resp_i while idle: ignored ----
        resp_i = 1'b1; burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
        tick(); tick(); tick();
        chk1("idle_resp_o", resp_o, 1'b0);
        chk1("idle_read_o", read_o, 1'b0);
        chk1("idle_write_o", write_o, 1'b0);
        chk("idle_line_o", line_o, exp_line);
        resp_i = 1'b0; burst_i = '0;

        // ---- reset after beat 2 of a read ----
        read_i = 1'b1; address_i = 32'h0000_0200;
        tick();                                         // cycle 1
        read_i = 1'b0; resp_i = 1'b1; burst_i = 64'h0101_0101_0101_0101;
        tick();                                         // cycle 2
        burst_i = 64'h0202_0202_0202_0202;
        tick();                                         // cycle 3, two beats taken
        resp_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk1("rstmid_read_o", read_o, 1'b0);
        chk("rstmid_addr", 256'(address_o), 256'd0);
        chk1("rstmid_resp_o", resp_o, 1'b0);
        chk("rstmid_line_o", line_o, 256'd0);
        tick();
        chk1("rstmid_resp_o_hold", resp_o, 1'b0);
        rst = 1'b0;
        tick();
        chk1("rstmid_resp_o_after", resp_o, 1'b0);
        // following read completes normally
        read_i = 1'b1; address_i = 32'h0000_0300;
        tick();
        read_i = 1'b0;
        chk1("post_read_o", read_o, 1'b1);
        chk("post_addr", 256'(address_o), 256'(32'h0000_0300));
        resp_i = 1'b1;
        for (int b = 0; b < 4; b++) begin
            burst_i = {16{4'(b + 7)}};
            tick();
        end
        resp_i = 1'b0; burst_i = '0;
        chk1("post_resp_o", resp_o, 1'b1);
        exp_line = {{16{4'hA}}, {16{4'h9}}, {16{4'h8}}, {16{4'h7}}};
        chk("post_line_o", line_o, exp_line);
        tick();
        chk1("post_idle_resp_o", resp_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cacheline_adapter.md
CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

Interface
- REQ-001 Parameter LINE_W, default 256, cache line width in bits.
- REQ-002 Parameter BURST_W, default 64, memory beat width in bits; BEATS = LINE_W/BURST_W = 4.
- REQ-003 clk  input  1  single clock; all state changes on its rising edge.
- REQ-004 rst  input  1  reset, asynchronous and active-high.
- REQ-005 read_i  input  1  line read request from the cache/arbiter side.
- REQ-006 write_i  input  1  line write request from the cache/arbiter side.
- REQ-007 address_i  input  32  line address of the request.
- REQ-008 line_i  input  LINE_W  write line data.
- REQ-009 line_o  output  LINE_W  assembled read line, registered.
- REQ-010 resp_o  output  1  one-cycle completion pulse to the requester.
- REQ-011 read_o  output  1  burst read request to memory.
- REQ-012 write_o  output  1  burst write request to memory.
- REQ-013 address_o  output  32  line-aligned memory address.
- REQ-014 burst_o  output  BURST_W  current write beat.
- REQ-015 burst_i  input  BURST_W  read beat from memory.
- REQ-016 resp_i  input  1  memory beat-valid; one beat transferred per cycle it is high.

Function
- REQ-017 The FSM SHALL have states IDLE, RD_BURST, WR_BURST and DONE.
- REQ-018 IDLE: read_o=write_o=resp_o=0; read_i=1 -> latch address, clear beat count, go RD_BURST; else write_i=1 -> latch address and line_i, clear count, go WR_BURST.
- REQ-019 Simultaneous read_i and write_i in IDLE SHALL start a read (read priority); the write is not queued.
- REQ-020 address_o SHALL equal {latched address[31:5], 5'b0} whenever read_o or write_o is high; it is 0 otherwise.
- REQ-021 RD_BURST: read_o=1 every cycle; on each resp_i=1, burst_i SHALL be stored in line slot [cnt*64 +: 64] (beat 0 = bits 63:0) and cnt SHALL increment.
- REQ-022 WR_BURST: write_o=1 every cycle; burst_o SHALL equal latched line[cnt*64 +: 64]; cnt SHALL increment on each resp_i=1.
- REQ-023 Beats need not be consecutive; a cycle with resp_i=0 in a burst state SHALL hold cnt and data.
- REQ-024 On resp_i=1 with cnt=3, the FSM SHALL go to DONE and cnt SHALL wrap to 0 (2-bit counter).
- REQ-025 DONE: resp_o=1 for exactly one cycle, read_o=write_o=0, then unconditionally IDLE; read_i/write_i are not sampled in DONE.
- REQ-026 line_o SHALL hold the last fully assembled read line until the next read's final beat; partial beats of a read SHALL not change line_o until DONE is entered (use a separate assembly buffer).
- REQ-027 burst_o SHALL be 0 outside WR_BURST.
- REQ-028 resp_i in IDLE or DONE SHALL be ignored.
- REQ-029 Changes of address_i, line_i, read_i or write_i during a burst SHALL not affect the in-flight transfer.
- REQ-030 Latency: request seen in IDLE at cycle 0, read_o/write_o high from cycle 1; with resp_i high on cycles 1-4, resp_o is high in cycle 5 and IDLE in cycle 6.

Reset
- REQ-031 rst=1 SHALL immediately (asynchronously) force IDLE, cnt=0, line_o=0, assembly buffer=0, latched address/line=0, all outputs 0.
- REQ-032 Reset asserted mid-burst SHALL abort the transfer with no resp_o; after release the block SHALL accept a new request normally.

Verification
- REQ-033 Read: address_i=0x1234_5678, read_i=1, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back -> address_o=0x1234_5660, resp_o in cycle 5, line_o={0x44..44,0x33..33,0x22..22,0x11..11}.
- REQ-034 Write: address_i=0x0000_0040, line_i=beats {D3,D2,D1,D0} -> burst_o=D0,D1,D2,D3 on successive resp_i cycles, write_o high cycles 1-4, resp_o cycle 5.
- REQ-035 Stalled read: resp_i pattern 1,0,0,1,1,0,1 -> exactly four beats captured in order, resp_o one cycle after the seventh pattern cycle, read_o high throughout.
- REQ-036 Simultaneous read_i=write_i=1 in IDLE -> read_o=1, write_o=0; line_o updates, no write beats issued.
- REQ-037 rst pulsed after beat 2 of a read -> outputs 0 within the same cycle, no resp_o, line_o=0; following read completes correctly.
- REQ-038 resp_i=1 while IDLE with no request -> no state change, resp_o stays 0, line_o unchanged.
